// File: rtl/inv_mix_columns_if.sv
// Handshake and data bundle for inv_mix_columns: state rows in, result rows out.
// The slave modport is the transform block; the master modport is its producer/consumer.
interface inv_mix_columns_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] line0;
  logic [31:0] line1;
  logic [31:0] line2;
  logic [31:0] line3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] outline0;
  logic [31:0] outline1;
  logic [31:0] outline2;
  logic [31:0] outline3;

  modport master (
    output in_valid, line0, line1, line2, line3, out_ready,
    input  in_ready, out_valid, outline0, outline1, outline2, outline3
  );

  modport slave (
    input  in_valid, line0, line1, line2, line3, out_ready,
    output in_ready, out_valid, outline0, outline1, outline2, outline3
  );
endinterface

// File: rtl/inv_mix_columns.sv
// AES InvMixColumns on a 4x4 byte state, COLS_PER_CYCLE columns per RUN cycle; out_valid N+1 edges after accept, held until out_ready.
// INV_MIX_COLUMNS_FWD_EN adds a decrypt input sampled at accept; decrypt=0 selects forward MixColumns with identical timing.
module inv_mix_columns #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef INV_MIX_COLUMNS_FWD_EN
  input  logic             decrypt,
`endif
  inv_mix_columns_if.slave bus,
  output logic             busy
);

  // One packed row of the state; element 0 is column 0 (bits [31:24]).
  typedef logic [0:3][7:0] vec_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] COL_LAST = 2'(4 - COLS_PER_CYCLE);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] col;
  vec_t       row     [4];
  vec_t       row_nxt [4];
  logic       accept;
  logic       last;
`ifdef INV_MIX_COLUMNS_FWD_EN
  logic       dec_q;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic vec_t inv_col(input vec_t s);
    vec_t x2, x4, x8, m9, mb, md, me, o;
    for (int k = 0; k < 4; k++) begin
      x2[k] = xtime(s[k]);
      x4[k] = xtime(x2[k]);
      x8[k] = xtime(x4[k]);
      m9[k] = x8[k] ^ s[k];
      mb[k] = x8[k] ^ x2[k] ^ s[k];
      md[k] = x8[k] ^ x4[k] ^ s[k];
      me[k] = x8[k] ^ x4[k] ^ x2[k];
    end
    // Circulant matrix: row r starts with 0E at column r.
    for (int r = 0; r < 4; r++)
      o[r] = me[r] ^ mb[(r + 1) % 4] ^ md[(r + 2) % 4] ^ m9[(r + 3) % 4];
    return o;
  endfunction

`ifdef INV_MIX_COLUMNS_FWD_EN
  function automatic vec_t fwd_col(input vec_t s);
    vec_t x2, o;
    for (int k = 0; k < 4; k++)
      x2[k] = xtime(s[k]);
    for (int r = 0; r < 4; r++)
      o[r] = x2[r] ^ x2[(r + 1) % 4] ^ s[(r + 1) % 4] ^ s[(r + 2) % 4] ^ s[(r + 3) % 4];
    return o;
  endfunction
`endif

  assign accept = bus.in_valid & bus.in_ready;
  assign last   = (col == COL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid)
          state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last)
          state_nxt = DONE;
      end
      DONE: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Columns col .. col+COLS_PER_CYCLE-1 are rewritten in place each RUN cycle.
  always_comb begin
    logic [1:0] c;
    vec_t       s;
    vec_t       t;
    row_nxt = row;
    c       = col;
    s       = '0;
    t       = '0;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      c = col + 2'(j);
      for (int k = 0; k < 4; k++)
        s[k] = row[k][c];
`ifdef INV_MIX_COLUMNS_FWD_EN
      t = dec_q ? inv_col(s) : fwd_col(s);
`else
      t = inv_col(s);
`endif
      for (int k = 0; k < 4; k++)
        row_nxt[k][c] = t[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '{default: '0};
`ifdef INV_MIX_COLUMNS_FWD_EN
      dec_q <= 1'b1;
`endif
    end else if (accept) begin
      col    <= '0;
      row[0] <= bus.line0;
      row[1] <= bus.line1;
      row[2] <= bus.line2;
      row[3] <= bus.line3;
`ifdef INV_MIX_COLUMNS_FWD_EN
      dec_q <= decrypt;
`endif
    end else if (state == RUN) begin
      col <= col + COL_STEP;
      row <= row_nxt;
    end
  end

  assign bus.outline0 = row[0];
  assign bus.outline1 = row[1];
  assign bus.outline2 = row[2];
  assign bus.outline3 = row[3];

endmodule
